load_align_unit: RTL and testbench

//  Sequential successor to the combinational load masker: accepts one load request, fetches 1 or 2 memory words,

---
 rtl/load_align_unit_if.sv | 38 +++
 rtl/load_align_unit.sv | 206 ++++++++++++++++++++
 tb/tb_load_align_unit.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_align_unit_if.sv
// Load-align bus bundle: request from the address stage, memory read port and writeback result.
// The unit itself connects through the slave modport; the surrounding pipeline/memory side uses master.
interface load_align_unit_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_mem_rw;
  logic [ADDR_W-1:0] req_addr;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_data;

  logic              ld_valid;
  logic              ld_ready;
  logic [XLEN-1:0]   ld_data;
  logic              ld_err;

  modport slave (
    input  req_valid, req_mem_rw, req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  ld_ready,
    output req_ready, mem_req_valid, mem_req_addr,
    output ld_valid, ld_data, ld_err
  );

  modport master (
    output req_valid, req_mem_rw, req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output ld_ready,
    input  req_ready, mem_req_valid, mem_req_addr,
    input  ld_valid, ld_data, ld_err
  );
endinterface

// File: rtl/load_align_unit.sv
// Sequential load unit: fetches one or two memory words per load, extracts the addressed
// bytes, sign/zero-extends them and hands the result to writeback. One load in flight.
// Build option LOAD_MISALIGN_EN: when defined, misaligned loads are serviced (word-spanning
// ones with a second memory beat); when undefined they complete immediately with ld_err.
module load_align_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  load_align_unit_if.slave bus
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned SH_W  = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    OUT   = 3'd5
  } state_t;

  state_t           state;
  logic [3:0]       size_q;
  logic             sign_q;
  logic [OFF_W-1:0] off_q;
`ifdef LOAD_MISALIGN_EN
  logic             span_q;
  logic [XLEN-1:0]  beat0_q;
`endif

  logic [OFF_W-1:0] req_off_c;
  logic [3:0]       size_c;
  logic             sign_c;
  logic             legal_c;
  logic             reject_c;
`ifdef LOAD_MISALIGN_EN
  logic             span_c;
`else
  logic             misal_c;
`endif

  assign req_off_c = bus.req_addr[OFF_W-1:0];

  // Decode the incoming op into access size, signedness and legality.
  always_comb begin
    size_c  = 4'd1;
    sign_c  = 1'b0;
    legal_c = 1'b1;
    unique case (bus.req_mem_rw)
      4'd0:    begin size_c = 4'd4; sign_c = 1'b1; end
      4'd1:    begin size_c = 4'd2; sign_c = 1'b1; end
      4'd2:    begin size_c = 4'd1; sign_c = 1'b1; end
      4'd3:    begin size_c = 4'd2; sign_c = 1'b0; end
      4'd4:    begin size_c = 4'd1; sign_c = 1'b0; end
      4'd5:    begin size_c = 4'd4; sign_c = 1'b0; end
      4'd6:    begin size_c = 4'd8; sign_c = 1'b0; legal_c = (XLEN == 64); end
      default: begin legal_c = 1'b0; end
    endcase
  end

  // Alignment classification of the incoming request.
`ifdef LOAD_MISALIGN_EN
  always_comb begin
    span_c   = (5'(req_off_c) + 5'(size_c)) > 5'(NB);
    reject_c = !legal_c;
  end
`else
  always_comb begin
    misal_c  = |(4'(req_off_c) & (size_c - 4'd1));
    reject_c = !legal_c || misal_c;
  end
`endif

  logic [2*XLEN-1:0] cat_c;
  logic [XLEN-1:0]   raw_c;
  logic [XLEN-1:0]   mask_c;
  logic [XLEN-1:0]   msb_c;
  logic [XLEN-1:0]   ext_c;
  logic [SH_W-1:0]   shamt_c;
  logic              sgn_c;

  // Extraction: shift the beat pair down by the byte offset, keep S bytes, extend.
  always_comb begin
`ifdef LOAD_MISALIGN_EN
    cat_c = (state == WAIT1) ? {bus.mem_rsp_data, beat0_q} : {XLEN'(0), bus.mem_rsp_data};
`else
    cat_c = {XLEN'(0), bus.mem_rsp_data};
`endif
    raw_c   = XLEN'(cat_c >> {off_q, 3'b000});
    shamt_c = {size_q, 3'b000};
    mask_c  = (shamt_c >= SH_W'(XLEN)) ? '1 : ((XLEN'(1) << shamt_c) - XLEN'(1));
    msb_c   = XLEN'(1) << (shamt_c - SH_W'(1));
    sgn_c   = sign_q & (|(raw_c & msb_c));
    ext_c   = (raw_c & mask_c) | (sgn_c ? ~mask_c : '0);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      size_q            <= 4'd1;
      sign_q            <= 1'b0;
      off_q             <= '0;
`ifdef LOAD_MISALIGN_EN
      span_q            <= 1'b0;
      beat0_q           <= '0;
`endif
      bus.req_ready     <= 1'b0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_addr  <= '0;
      bus.ld_valid      <= 1'b0;
      bus.ld_data       <= '0;
      bus.ld_err        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            size_q        <= size_c;
            sign_q        <= sign_c;
            off_q         <= req_off_c;
`ifdef LOAD_MISALIGN_EN
            span_q        <= span_c;
`endif
            if (reject_c) begin
              bus.ld_valid <= 1'b1;
              bus.ld_err   <= 1'b1;
              bus.ld_data  <= '0;
              state        <= OUT;
            end else begin
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_addr  <= {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
              state             <= REQ0;
            end
          end
        end
        REQ0: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= WAIT0;
          end
        end
        WAIT0: begin
          if (bus.mem_rsp_valid) begin
`ifdef LOAD_MISALIGN_EN
            beat0_q <= bus.mem_rsp_data;
            if (span_q) begin
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_addr  <= bus.mem_req_addr + ADDR_W'(NB);
              state             <= REQ1;
            end else begin
              bus.ld_valid <= 1'b1;
              bus.ld_err   <= 1'b0;
              bus.ld_data  <= ext_c;
              state        <= OUT;
            end
`else
            bus.ld_valid <= 1'b1;
            bus.ld_err   <= 1'b0;
            bus.ld_data  <= ext_c;
            state        <= OUT;
`endif
          end
        end
`ifdef LOAD_MISALIGN_EN
        REQ1: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= WAIT1;
          end
        end
        WAIT1: begin
          if (bus.mem_rsp_valid) begin
            bus.ld_valid <= 1'b1;
            bus.ld_err   <= 1'b0;
            bus.ld_data  <= ext_c;
            state        <= OUT;
          end
        end
`endif
        OUT: begin
          if (bus.ld_ready) begin
            bus.ld_valid  <= 1'b0;
            bus.ld_err    <= 1'b0;
            bus.ld_data   <= '0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          bus.req_ready     <= 1'b0;
          bus.mem_req_valid <= 1'b0;
          bus.ld_valid      <= 1'b0;
          state             <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: one RV32 and one RV64 instance. Expected memory
// addresses and results are queued at issue time; monitors pop and compare on handshakes.
// Expectations follow the LOAD_MISALIGN_EN build option.
module tb_load_align_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_align_unit_if #(.XLEN(32), .ADDR_W(32)) b32 ();
  load_align_unit_if #(.XLEN(64), .ADDR_W(32)) b64 ();

  load_align_unit #(.XLEN(32), .ADDR_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  load_align_unit #(.XLEN(64), .ADDR_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t        ldq32[$];
  exp_t        ldq64[$];
  logic [31:0] aq32[$];
  logic [31:0] aq64[$];
  logic [63:0] dq32[$];
  logic [63:0] dq64[$];

  int n_checks = 0;
  int n_fail   = 0;
  int lat32    = 1;
  int reqs32   = 0;
  int reqs64   = 0;
  logic        pend32 = 1'b0;
  logic        pend64 = 1'b0;
  int          cnt32  = 0;
  int          cnt64  = 0;
  logic [63:0] pd32;
  logic [63:0] pd64;
  exp_t        m32;
  exp_t        m64;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%h, none was required", name, act);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Memory model, RV32 side: checks request addresses, answers lat32 cycles later.
  always @(negedge clk) begin
    b32.mem_rsp_valid = 1'b0;
    if (pend32) begin
      if (cnt32 <= 0) begin
        b32.mem_rsp_valid = 1'b1;
        b32.mem_rsp_data  = pd32[31:0];
        pend32 = 1'b0;
      end else begin
        cnt32--;
      end
    end
    if (rst_n && b32.mem_req_valid && b32.mem_req_ready) begin
      reqs32++;
      if (aq32.size() == 0) unexpected("mem_addr32", 64'(b32.mem_req_addr));
      else check("mem_addr32", 64'(b32.mem_req_addr), 64'(aq32.pop_front()));
      pd32   = (dq32.size() != 0) ? dq32.pop_front() : 64'd0;
      pend32 = 1'b1;
      cnt32  = lat32 - 1;
    end
  end

  // Memory model, RV64 side: fixed one-cycle response latency.
  always @(negedge clk) begin
    b64.mem_rsp_valid = 1'b0;
    if (pend64) begin
      if (cnt64 <= 0) begin
        b64.mem_rsp_valid = 1'b1;
        b64.mem_rsp_data  = pd64;
        pend64 = 1'b0;
      end else begin
        cnt64--;
      end
    end
    if (rst_n && b64.mem_req_valid && b64.mem_req_ready) begin
      reqs64++;
      if (aq64.size() == 0) unexpected("mem_addr64", 64'(b64.mem_req_addr));
      else check("mem_addr64", 64'(b64.mem_req_addr), 64'(aq64.pop_front()));
      pd64   = (dq64.size() != 0) ? dq64.pop_front() : 64'd0;
      pend64 = 1'b1;
      cnt64  = 0;
    end
  end

  // Result monitors: compare on each ld_valid/ld_ready handshake.
  always @(negedge clk) begin
    if (rst_n && b32.ld_valid && b32.ld_ready) begin
      if (ldq32.size() == 0) unexpected("ld32", 64'(b32.ld_data));
      else begin
        m32 = ldq32.pop_front();
        check("ld_data32", 64'(b32.ld_data), m32.data);
        check("ld_err32", 64'(b32.ld_err), 64'(m32.err));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b64.ld_valid && b64.ld_ready) begin
      if (ldq64.size() == 0) unexpected("ld64", b64.ld_data);
      else begin
        m64 = ldq64.pop_front();
        check("ld_data64", b64.ld_data, m64.data);
        check("ld_err64", 64'(b64.ld_err), 64'(m64.err));
      end
    end
  end

  task automatic expect32(input int n, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [63:0] data, input logic err);
    exp_t e;
    e.data = data;
    e.err  = err;
    ldq32.push_back(e);
    if (n > 0) begin aq32.push_back(a0); dq32.push_back(64'(d0)); end
    if (n > 1) begin aq32.push_back(a1); dq32.push_back(64'(d1)); end
  endtask

  task automatic send32(input logic [3:0] op, input logic [31:0] addr);
    int i;
    @(negedge clk);
    b32.req_valid  = 1'b1;
    b32.req_mem_rw = op;
    b32.req_addr   = addr;
    i = 0;
    while (!b32.req_ready && i < 50) begin @(negedge clk); i++; end
    if (!b32.req_ready) timeout("req_accept32");
    @(negedge clk);
    b32.req_valid = 1'b0;
  endtask

  task automatic drain32();
    int i;
    i = 0;
    while (ldq32.size() != 0 && i < 100) begin @(negedge clk); i++; end
    if (ldq32.size() != 0) begin timeout("ld_done32"); ldq32.delete(); end
    check("mem_reqs_left32", 64'(aq32.size()), 64'd0);
    aq32.delete();
    dq32.delete();
  endtask

  task automatic ld32(input logic [3:0] op, input logic [31:0] addr, input int n,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [63:0] data, input logic err);
    expect32(n, a0, a1, d0, d1, data, err);
    send32(op, addr);
    drain32();
  endtask

  task automatic ld64(input logic [3:0] op, input logic [31:0] addr, input int n,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [63:0] d0, input logic [63:0] d1,
                      input logic [63:0] data, input logic err);
    exp_t e;
    int i;
    e.data = data;
    e.err  = err;
    ldq64.push_back(e);
    if (n > 0) begin aq64.push_back(a0); dq64.push_back(d0); end
    if (n > 1) begin aq64.push_back(a1); dq64.push_back(d1); end
    @(negedge clk);
    b64.req_valid  = 1'b1;
    b64.req_mem_rw = op;
    b64.req_addr   = addr;
    i = 0;
    while (!b64.req_ready && i < 50) begin @(negedge clk); i++; end
    if (!b64.req_ready) timeout("req_accept64");
    @(negedge clk);
    b64.req_valid = 1'b0;
    i = 0;
    while (ldq64.size() != 0 && i < 100) begin @(negedge clk); i++; end
    if (ldq64.size() != 0) begin timeout("ld_done64"); ldq64.delete(); end
    check("mem_reqs_left64", 64'(aq64.size()), 64'd0);
    aq64.delete();
    dq64.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i;
    int start;
    int target;
    rst_n = 1'b0;
    b32.req_valid = 1'b0; b32.req_mem_rw = 4'd0; b32.req_addr = '0;
    b32.mem_req_ready = 1'b1; b32.mem_rsp_valid = 1'b0; b32.mem_rsp_data = '0; b32.ld_ready = 1'b1;
    b64.req_valid = 1'b0; b64.req_mem_rw = 4'd0; b64.req_addr = '0;
    b64.mem_req_ready = 1'b1; b64.mem_rsp_valid = 1'b0; b64.mem_rsp_data = '0; b64.ld_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_ready32", 64'(b32.req_ready), 64'd0);
    check("rst_mem_req_valid32", 64'(b32.mem_req_valid), 64'd0);
    check("rst_ld_valid32", 64'(b32.ld_valid), 64'd0);
    check("rst_ld_err32", 64'(b32.ld_err), 64'd0);
    check("rst_ld_data32", 64'(b32.ld_data), 64'd0);
    check("rst_req_ready64", 64'(b64.req_ready), 64'd0);
    check("rst_ld_data64", b64.ld_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready32", 64'(b32.req_ready), 64'd1);
    check("post_rst_req_ready64", 64'(b64.req_ready), 64'd1);

    // RV32 aligned loads
    ld32(4'd2, 32'h103, 1, 32'h100, 0, 32'h80332211, 0, 64'hFFFFFF80, 1'b0);
    ld32(4'd3, 32'h102, 1, 32'h100, 0, 32'h9ABC5678, 0, 64'h00009ABC, 1'b0);
    ld32(4'd1, 32'h102, 1, 32'h100, 0, 32'h9ABC5678, 0, 64'hFFFF9ABC, 1'b0);
    ld32(4'd0, 32'h4, 1, 32'h4, 0, 32'h80000000, 0, 64'h80000000, 1'b0);
    ld32(4'd5, 32'h4, 1, 32'h4, 0, 32'h80000000, 0, 64'h80000000, 1'b0);
    ld32(4'd1, 32'hFFFFFFFE, 1, 32'hFFFFFFFC, 0, 32'h7FFF0000, 0, 64'h00007FFF, 1'b0);

    // Memory port back-pressure on the request
    @(posedge clk); #1 b32.mem_req_ready = 1'b0;
    fork
      ld32(4'd4, 32'h101, 1, 32'h100, 0, 32'h0000F100, 0, 64'h000000F1, 1'b0);
      begin repeat (4) @(posedge clk); #1 b32.mem_req_ready = 1'b1; end
    join

    // Illegal op codes on RV32
    ld32(4'd6, 32'h0, 0, 0, 0, 0, 0, 64'd0, 1'b1);
    ld32(4'd15, 32'h8, 0, 0, 0, 0, 0, 64'd0, 1'b1);

    // Misaligned loads
`ifdef LOAD_MISALIGN_EN
    ld32(4'd0, 32'h203, 2, 32'h200, 32'h204, 32'h44332211, 32'h88776655, 64'h77665544, 1'b0);
    ld32(4'd1, 32'hFFFFFFFF, 2, 32'hFFFFFFFC, 32'h0, 32'hAA000000, 32'h000000BB, 64'hFFFFBBAA, 1'b0);
    ld32(4'd1, 32'h101, 1, 32'h100, 0, 32'h00CDAB00, 0, 64'hFFFFCDAB, 1'b0);
`else
    ld32(4'd0, 32'h203, 0, 0, 0, 0, 0, 64'd0, 1'b1);
    ld32(4'd1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 64'd0, 1'b1);
    ld32(4'd1, 32'h101, 0, 0, 0, 0, 0, 64'd0, 1'b1);
`endif

    // Result held while writeback stalls
    expect32(1, 32'h10, 0, 32'h12345678, 0, 64'h12345678, 1'b0);
    @(posedge clk); #1 b32.ld_ready = 1'b0;
    send32(4'd0, 32'h10);
    i = 0;
    while (!b32.ld_valid && i < 50) begin @(negedge clk); i++; end
    if (!b32.ld_valid) timeout("stall_ld_valid32");
    repeat (5) begin
      check("stall_ld_valid32", 64'(b32.ld_valid), 64'd1);
      check("stall_ld_data32", 64'(b32.ld_data), 64'h12345678);
      check("stall_req_ready32", 64'(b32.req_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 b32.ld_ready = 1'b1;
    drain32();

    // Reset while waiting on memory, then a stale response arrives in IDLE
    lat32 = 6;
    start = reqs32;
`ifdef LOAD_MISALIGN_EN
    target = 2;
    aq32.push_back(32'h200); dq32.push_back(64'h44332211);
    aq32.push_back(32'h204); dq32.push_back(64'h88776655);
    send32(4'd0, 32'h203);
`else
    target = 1;
    aq32.push_back(32'h200); dq32.push_back(64'h11111111);
    send32(4'd0, 32'h200);
`endif
    i = 0;
    while (reqs32 < start + target && i < 100) begin @(negedge clk); i++; end
    if (reqs32 < start + target) timeout("abort_mem_req32");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_req_ready32", 64'(b32.req_ready), 64'd0);
    check("abort_mem_req_valid32", 64'(b32.mem_req_valid), 64'd0);
    check("abort_ld_valid32", 64'(b32.ld_valid), 64'd0);
    check("abort_ld_err32", 64'(b32.ld_err), 64'd0);
    check("abort_ld_data32", 64'(b32.ld_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("stale_ld_valid32", 64'(b32.ld_valid), 64'd0);
      check("stale_mem_req_valid32", 64'(b32.mem_req_valid), 64'd0);
    end
    aq32.delete();
    dq32.delete();
    lat32 = 1;
    ld32(4'd0, 32'h0, 1, 32'h0, 0, 32'hCAFEF00D, 0, 64'hCAFEF00D, 1'b0);

    // RV64 loads
    ld64(4'd5, 32'h14, 1, 32'h10, 0, 64'h89ABCDEF_00000000, 0, 64'h00000000_89ABCDEF, 1'b0);
    ld64(4'd0, 32'h14, 1, 32'h10, 0, 64'h89ABCDEF_00000000, 0, 64'hFFFFFFFF_89ABCDEF, 1'b0);
    ld64(4'd6, 32'h8, 1, 32'h8, 0, 64'h11223344_55667788, 0, 64'h11223344_55667788, 1'b0);
    ld64(4'd2, 32'h17, 1, 32'h10, 0, 64'h89ABCDEF_00000000, 0, 64'hFFFFFFFF_FFFFFF89, 1'b0);
    ld64(4'd3, 32'h1E, 1, 32'h18, 0, 64'h80000000_00000000, 0, 64'h00000000_00008000, 1'b0);
    ld64(4'd7, 32'h0, 0, 0, 0, 0, 0, 64'd0, 1'b1);
`ifdef LOAD_MISALIGN_EN
    ld64(4'd6, 32'h4, 2, 32'h0, 32'h8, 64'hAAAAAAAA_BBBBBBBB, 64'hCCCCCCCC_DDDDDDDD,
         64'hDDDDDDDD_AAAAAAAA, 1'b0);
`else
    ld64(4'd6, 32'h4, 0, 0, 0, 0, 0, 64'd0, 1'b1);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
